// File: rtl/ecall_input_port_pkg.sv
// Shared types and constants for the ecall input front-end.
package ecall_input_port_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARM        = 2'd1,
    WAIT_PRESS = 2'd2
  } state_e;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 200000;

endpackage

// File: rtl/ecall_input_port_if.sv
// Request/result handshake between the ecall handler (master) and the input port (slave).
interface ecall_input_port_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  sign_i;
  logic                  cancel_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] data_o;

  modport master (
    output req_i, sign_i, cancel_i,
    input  busy_o, done_o, data_o
  );

  modport slave (
    input  req_i, sign_i, cancel_i,
    output busy_o, done_o, data_o
  );
endinterface

// File: rtl/ecall_input_port_btn_debounce.sv
// Button synchroniser + debouncer; emits a clean level and a one-cycle press pulse.
module btn_debounce
  import ecall_input_port_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             btn_s_q, btn_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic             press_q, press_d;

  always_comb begin
    meta_d       = raw_i;
    btn_s_d      = meta_q;
    cnt_d        = cnt_q;
    level_d      = level_q;
    level_prev_d = level_q;
    press_d      = level_q & ~level_prev_q;
    // Level flips only after the synced input has disagreed for DEBOUNCE_CYCLES edges in a row.
    if (btn_s_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = btn_s_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q       <= 1'b0;
      btn_s_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      btn_s_q      <= btn_s_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/ecall_input_port.sv
// Ecall input front-end: waits for a fresh debounced press, returns extended switch value.
module ecall_input_port
  import ecall_input_port_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button_i,
  input  logic [SW_WIDTH-1:0] switches_i,
  ecall_input_port_if.slave   bus,
  output logic                btn_level_o
);

  logic db_level;
  logic press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (button_i),
    .level_o (db_level),
    .press_o (press)
  );

  logic [SW_WIDTH-1:0]   sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0]   sw_s_q, sw_s_d;
  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ext_fill;

  assign ext_fill = (sign_q == EXT_SIGN) & sw_s_q[SW_WIDTH-1];

  always_comb begin
    sw_meta_d = switches_i;
    sw_s_d    = sw_meta_q;
    state_d   = state_q;
    sign_d    = sign_q;
    done_d    = 1'b0;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (bus.req_i && !bus.cancel_i) begin
          sign_d  = bus.sign_i;
          // A button already held must be released before it can satisfy this read.
          state_d = db_level ? ARM : WAIT_PRESS;
        end
      end
      ARM: begin
        if (bus.cancel_i)   state_d = IDLE;
        else if (!db_level) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (bus.cancel_i) begin
          state_d = IDLE;
        end else if (press) begin
          data_d  = {{(DATA_WIDTH-SW_WIDTH){ext_fill}}, sw_s_q};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      state_q   <= IDLE;
      sign_q    <= EXT_ZERO;
      done_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_s_q    <= sw_s_d;
      state_q   <= state_d;
      sign_q    <= sign_d;
      done_q    <= done_d;
      data_q    <= data_d;
    end
  end

  assign bus.busy_o  = (state_q != IDLE);
  assign bus.done_o  = done_q;
  assign bus.data_o  = data_q;
  assign btn_level_o = db_level;

endmodule

// File: doc/ecall_input_port.md
Name: ecall_input_port

Overview:
- Upstream input front-end for the ecall I/O path; sits between the board pins (button, switches) and the ecall handler in EX.
- Synchronises and debounces the confirm button. On a read request it waits for a fresh debounced button press, then returns the synchronised switch value as a 32-bit result with a one-cycle done pulse.
- Owns all metastability and bounce handling, so the ecall handler sees only clean, single-cycle events.

Parameters:
- DEBOUNCE_CYCLES, 200000, consecutive stable cycles required before the debounced level changes (minimum 2).
- SW_WIDTH, 8, switch bank width.
- DATA_WIDTH, 32, result width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- button_i  in  1  raw confirm button, asynchronous
- switches_i  in  SW_WIDTH  raw switches, asynchronous
- req_i  in  1  one-cycle read request from the ecall handler
- sign_i  in  1  sampled with req_i; 1 = sign-extend from bit SW_WIDTH-1, 0 = zero-extend
- cancel_i  in  1  pipeline flush; aborts any pending read
- busy_o  out  1  high while a read is pending (state != IDLE)
- done_o  out  1  one-cycle result-valid pulse
- data_o  out  DATA_WIDTH  result; holds its value until the next done_o
- btn_level_o  out  1  debounced button level, for display/debug

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, debounce counter 0, debounced level 0, all synchroniser flops 0.
- Synchronisers: 2-flop chain on button_i and on each switches_i bit; the second-stage outputs are btn_s and sw_s.
- Debounce counter:
  - btn_s == db_level: cnt <= 0.
  - Otherwise cnt increments; when cnt == DEBOUNCE_CYCLES-1 and btn_s still differs, db_level <= btn_s and cnt <= 0.
  - Any glitch back to db_level before the terminal count resets cnt.
- Press event: registered one-cycle pulse, press <= db_level & ~db_level_q.
- Latency: raw rising edge at edge 0 -> btn_s at edge 2 -> db_level at edge 2+DEBOUNCE_CYCLES -> press at edge 3+DEBOUNCE_CYCLES -> done_o at edge 4+DEBOUNCE_CYCLES.
- FSM states: IDLE, ARM, WAIT_PRESS.
  - IDLE: on req_i & ~cancel_i, latch sign_i. Go to ARM if db_level == 1 (button already held), else WAIT_PRESS.
  - ARM: wait for db_level == 0, then go to WAIT_PRESS. A held button never satisfies a new request; a release is required first.
  - WAIT_PRESS: on press, register data_o <= extend(sw_s, latched sign), pulse done_o for one cycle, go to IDLE.
  - Any non-IDLE state: cancel_i -> IDLE, no done_o, data_o unchanged.
- Simultaneous events:
  - cancel_i with press in WAIT_PRESS: cancel wins, no done_o.
  - cancel_i with req_i in IDLE: request ignored.
  - req_i while busy_o = 1: ignored; no queueing.
- Press with no request pending (IDLE): discarded, never stored.
- done_o is 0 in every cycle except the single completion cycle; a new req_i may arrive in that same cycle (state is already IDLE).
- Extension: zero-extend fills bits DATA_WIDTH-1..SW_WIDTH with 0; sign-extend fills them with sw_s[SW_WIDTH-1].
- Switch value is the one captured at the press event, not at the request.
- Reset asserted mid-transaction: immediate return to IDLE, busy_o = 0, no done_o after reset release.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE = 2'd0, ARM = 2'd1, WAIT_PRESS = 2'd2).
  - Extension-mode constants EXT_ZERO = 1'b0, EXT_SIGN = 1'b1.
  - Default DEBOUNCE_CYCLES constant.
- Sub-module btn_debounce: 2-flop synchroniser, counter, db_level and registered press pulse. Parameter DEBOUNCE_CYCLES; ports clk, rst, raw_i, level_o, press_o.
- The top level keeps the switch synchronisers, FSM and extension logic.

Test Plan (DEBOUNCE_CYCLES = 4):
- req_i, sign_i = 0, switches = 8'hA5, clean button rise at edge 0 -> done_o at edge 8 only, data_o = 32'h000000A5, busy_o = 0 after edge 8.
- Same stimulus with sign_i = 1 -> data_o = 32'hFFFFFFA5. With switches = 8'h5A -> 32'h0000005A.
- Bounce: button toggles 1/0 every 2 cycles for 10 cycles, then stays 1 -> db_level changes only after 4 stable cycles; exactly one done_o.
- Button held before req_i -> no done_o while held; release, then press -> exactly one done_o with the switch value at the new press.
- cancel_i asserted in the same cycle as press in WAIT_PRESS -> no done_o, state IDLE, data_o keeps its old value; a later req_i and press complete normally.
- rst pulsed while in WAIT_PRESS -> all outputs 0 immediately, asynchronously; no done_o after release. A press with no request pending produces no done_o and is not consumed by a later req_i.
